// File: rtl/risc_pkg.sv
// Shared datapath definitions: word width and steering destination encoding.
package risc_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic {
    DEST_OUT0 = 1'b0,
    DEST_OUT1 = 1'b1
  } dest_e;

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO holding words steered to one destination.
// Count-based full/empty. The read data is forced to zero while the FIFO is empty.
module demux_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Guard against overflow/underflow locally so the FIFO is safe on its own.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign rdata = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/demux1_to_2_buf.sv
// Registered 1-to-2 steering block with an independent FIFO per destination.
// Optional macro DEMUX_STEER_COUNT_EN adds per-destination accepted-word counters cnt0/cnt1.
module demux1_to_2_buf
  import risc_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_STEER_COUNT_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  dest_e w_sel;
  logic  w_accept;
  logic  w_push0;
  logic  w_push1;
  logic  w_pop0;
  logic  w_pop1;
  logic  w_full0;
  logic  w_full1;
  logic  w_empty0;
  logic  w_empty1;

  assign w_sel = dest_e'(in_sel);

  // Ready comes only from registered FIFO state, so a full FIFO stays
  // closed for one cycle even if it is popped in that same cycle.
  assign in_ready = (w_sel == DEST_OUT1) ? ~w_full1 : ~w_full0;
  assign w_accept = in_valid & in_ready;
  assign w_push0  = w_accept & (w_sel == DEST_OUT0);
  assign w_push1  = w_accept & (w_sel == DEST_OUT1);

  assign out0_valid = ~w_empty0;
  assign out1_valid = ~w_empty1;
  assign w_pop0     = out0_valid & out0_ready;
  assign w_pop1     = out1_valid & out1_ready;

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push0),
    .wdata (in_data),
    .full  (w_full0),
    .pop   (w_pop0),
    .rdata (out0_data),
    .empty (w_empty0)
  );

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push1),
    .wdata (in_data),
    .full  (w_full1),
    .pop   (w_pop1),
    .rdata (out1_data),
    .empty (w_empty1)
  );

`ifdef DEMUX_STEER_COUNT_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_push0) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_push1) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_demux1_to_2_buf.sv
// Directed scoreboard bench for demux1_to_2_buf; per-destination queues model FIFO contents.
module tb_demux1_to_2_buf;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel;
  logic [15:0] in_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [15:0] out1_data;
`ifdef DEMUX_STEER_COUNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  int checks   = 0;
  int failures = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        last_acc;

  always #5 clk = ~clk;

  demux1_to_2_buf #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX_STEER_COUNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s: got timeout expected completion", tag);
  endtask

  // Compare the DUT against the queue model, then apply this cycle's pops/pushes to the model.
  task automatic sample();
    int  sz_sel;
    logic acc;
    sz_sel = in_sel ? q1.size() : q0.size();
    chk("in_ready", in_ready, sz_sel != DEPTH);
    chk("out0_valid", out0_valid, q0.size() != 0);
    chk("out1_valid", out1_valid, q1.size() != 0);
    if (q0.size() == 0) chk("out0_data_zero", out0_data, 16'h0);
    else                chk("out0_data", out0_data, q0[0]);
    if (q1.size() == 0) chk("out1_data_zero", out1_data, 16'h0);
    else                chk("out1_data", out1_data, q1[0]);
    acc = in_valid && (sz_sel != DEPTH);
    if (q0.size() != 0 && out0_ready) void'(q0.pop_front());
    if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
    if (acc) begin
      if (in_sel) q1.push_back(in_data);
      else        q0.push_back(in_data);
    end
    last_acc = acc;
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic sel, input logic [15:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    last_acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) timeout("send");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      cycle();
    end
    if (q0.size() != 0 || q1.size() != 0) timeout("drain");
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out0_valid", out0_valid, 1'b0);
    chk("rst_out1_valid", out1_valid, 1'b0);
    chk("rst_out0_data", out0_data, 16'h0);
    chk("rst_out1_data", out1_data, 16'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) cycle();

    // Routing with one-cycle latency
    send(1'b0, 16'hA5A5);
    chk("route0_valid", out0_valid, 1'b1);
    chk("route0_data", out0_data, 16'hA5A5);
    send(1'b1, 16'h5A5A);
    chk("route1_valid", out1_valid, 1'b1);
    chk("route1_data", out1_data, 16'h5A5A);
    chk("route0_popped", out0_valid, 1'b0);
    drain();

    // Backpressure on out0, out1 still flowing
    out0_ready = 1'b0;
    send(1'b0, 16'h0001);
    send(1'b0, 16'h0002);
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 16'h0003;
    cycle();
    chk("bp_full_ready", in_ready, 1'b0);
    chk("bp_hold_data", out0_data, 16'h0001);
    send(1'b1, 16'h1111);
    out0_ready = 1'b1;
    send(1'b0, 16'h0003);
    drain();

    // Simultaneous push and pop on out1
    out1_ready = 1'b0;
    send(1'b1, 16'h00B1);
    out1_ready = 1'b1;
    in_valid   = 1'b1;
    in_sel     = 1'b1;
    in_data    = 16'h00B2;
    cycle();
    in_valid   = 1'b0;
    out1_ready = 1'b0;
    chk("pp_valid", out1_valid, 1'b1);
    chk("pp_data", out1_data, 16'h00B2);
    chk("pp_ready", in_ready, 1'b1);
    cycle();
    out1_ready = 1'b1;
    drain();

    // Asynchronous reset with both FIFOs full
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(1'b0, 16'hC000);
    send(1'b0, 16'hC001);
    send(1'b1, 16'hD000);
    send(1'b1, 16'hD001);
    in_sel = 1'b0;
    chk("full0_ready", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out0_valid", out0_valid, 1'b0);
    chk("arst_out1_valid", out1_valid, 1'b0);
    chk("arst_out0_data", out0_data, 16'h0);
    chk("arst_out1_data", out1_data, 16'h0);
    chk("arst_in_ready", in_ready, 1'b1);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (3) cycle();

`ifdef DEMUX_STEER_COUNT_EN
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    chk("cnt_rst0", cnt0, 16'h0);
    chk("cnt_rst1", cnt1, 16'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 16'h7777;
    repeat (65537) @(posedge clk);
    #1 in_valid = 1'b0;
    chk("cnt0_wrap", cnt0, 16'h0001);
    chk("cnt1_idle", cnt1, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
